multicycle_ctrl: RTL and testbench

- Multi-cycle control unit for the rysy RISC-V core: it sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states instead of decoding everything in one cycle.
- It drives the same datapath selects as the single-cycle controller, plus a req/ack memory handshake, a memory timeout, an illegal-opcode trap and a retired-instruction counter.
- It sits between the instruction register and the register file, ALU, PC and memory muxes.

---
 rtl/multicycle_ctrl_if.sv | 13 +
 rtl/multicycle_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: memory handshake between the multi-cycle controller
// and the instruction/data memory.
//   mem_req : controller -> memory, access request
//   mem_we  : controller -> memory, write (STORE data phase)
//   mem_ack : memory -> controller, transfer complete this cycle
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic mem_ack;

  modport master (output mem_req, output mem_we, input mem_ack);
  modport slave  (input mem_req, input mem_we, output mem_ack);
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle control unit for the rysy RISC-V core.
// Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB (plus TRAP)
// and drives the datapath selects, the memory handshake, a memory timeout,
// an illegal-opcode trap and a retired-instruction counter.
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   mem                 memory handshake (req/we out, ack in)
//   opcode/func3/func7  IR fields, stable from DECODE to end of instruction
//   b                   branch comparator result (1 = taken)
//   ir_we, pc_we        IR / PC write enables
//   pc_sel              0 PC+4, 1 ALU target, 2 JALR target, 3 trap vector
//   alu_op, alu1_sel, alu2_sel, imm_type, rd_sel, reg_wr  datapath controls
//   trap, trap_cause    one-cycle trap pulse, sticky cause (1 illegal, 2 timeout)
//   instret             retired-instruction count (wraps)
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  multicycle_ctrl_if.master mem,
  input  logic [4:0]        opcode,
  input  logic [2:0]        func3,
  input  logic [6:0]        func7,
  input  logic              b,
  output logic              ir_we,
  output logic              pc_we,
  output logic [1:0]        pc_sel,
  output logic [3:0]        alu_op,
  output logic              alu1_sel,
  output logic              alu2_sel,
  output logic [2:0]        imm_type,
  output logic [1:0]        rd_sel,
  output logic              reg_wr,
  output logic              trap,
  output logic [1:0]        trap_cause,
  output logic [CNT_W-1:0]  instret
);

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;

  localparam int unsigned TMO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_t;
  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_t;

  state_t             state_q, state_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [1:0]         cause_q, cause_d;
  logic [CNT_W-1:0]   instret_q, instret_d;

  logic               legal, alt_f7, tmo_hit;
  alu_t               f3_op, dec_alu_op;
  imm_t               dec_imm;
  logic               dec_alu1, dec_alu2;

  assign alt_f7  = (func7 == 7'b0100000);
  assign tmo_hit = (MEM_TIMEOUT != 0) && (tmo_q == TMO_W'(MEM_TIMEOUT - 1));

  // ALU operation implied by func3; SUB only exists for register-register OP.
  always_comb begin
    f3_op = ALU_ADD;
    case (func3)
      3'b000:  f3_op = (alt_f7 && opcode == OPC_OP) ? ALU_SUB : ALU_ADD;
      3'b001:  f3_op = ALU_SLL;
      3'b010:  f3_op = ALU_SLT;
      3'b011:  f3_op = ALU_SLTU;
      3'b100:  f3_op = ALU_XOR;
      3'b101:  f3_op = alt_f7 ? ALU_SRA : ALU_SRL;
      3'b110:  f3_op = ALU_OR;
      default: f3_op = ALU_AND;
    endcase
  end

  // Static decode of the IR; held from DECODE through WB so the ALU result
  // (address, link target) stays valid in MEM and WB.
  always_comb begin
    legal      = 1'b1;
    dec_alu_op = ALU_ADD;
    dec_alu1   = 1'b0;
    dec_alu2   = 1'b1;
    dec_imm    = IMM_I;
    case (opcode)
      OPC_OP:     begin dec_alu_op = f3_op; dec_alu2 = 1'b0; end
      OPC_OP_IMM: dec_alu_op = f3_op;
      OPC_LOAD:   dec_imm = IMM_I;
      OPC_STORE:  dec_imm = IMM_S;
      OPC_LUI:    begin dec_alu_op = ALU_PASS_B; dec_imm = IMM_U; end
      OPC_JAL:    begin dec_alu1 = 1'b1; dec_imm = IMM_J; end
      OPC_JALR:   dec_imm = IMM_I;
      OPC_BRANCH: begin dec_alu1 = 1'b1; dec_imm = IMM_B; end
      default:    begin legal = 1'b0; dec_alu2 = 1'b0; end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    tmo_d       = '0;
    cause_d     = cause_q;
    mem.mem_req = 1'b0;
    mem.mem_we  = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    pc_sel      = 2'd0;
    alu_op      = ALU_ADD;
    alu1_sel    = 1'b0;
    alu2_sel    = 1'b0;
    imm_type    = IMM_I;
    rd_sel      = 2'd0;
    reg_wr      = 1'b0;
    trap        = 1'b0;

    if (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
      alu_op   = dec_alu_op;
      alu1_sel = dec_alu1;
      alu2_sel = dec_alu2;
      imm_type = dec_imm;
    end

    case (state_q)
      S_FETCH: begin
        mem.mem_req = 1'b1;
        if (mem.mem_ack) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (tmo_hit) begin
          state_d = S_TRAP;
          cause_d = 2'd2;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_DECODE: begin
        if (legal) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_TRAP;
          cause_d = 2'd1;
        end
      end
      S_EXEC: begin
        if (opcode == OPC_BRANCH) begin
          pc_we   = 1'b1;
          pc_sel  = b ? 2'd1 : 2'd0;
          state_d = S_FETCH;
        end else if (opcode == OPC_LOAD || opcode == OPC_STORE) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem.mem_req = 1'b1;
        mem.mem_we  = (opcode == OPC_STORE);
        if (mem.mem_ack) begin
          if (opcode == OPC_STORE) begin
            pc_we   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (tmo_hit) begin
          state_d = S_TRAP;
          cause_d = 2'd2;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_WB: begin
        reg_wr  = 1'b1;
        pc_we   = 1'b1;
        state_d = S_FETCH;
        case (opcode)
          OPC_LOAD: rd_sel = 2'd1;
          OPC_JAL:  begin rd_sel = 2'd2; pc_sel = 2'd1; end
          OPC_JALR: begin rd_sel = 2'd2; pc_sel = 2'd2; end
          default:  rd_sel = 2'd0;
        endcase
      end
      default: begin
        trap    = 1'b1;
        pc_we   = 1'b1;
        pc_sel  = 2'd3;
        state_d = S_FETCH;
      end
    endcase

    // Reset forces the Moore outputs low immediately, not on the next edge.
    if (!rst) begin
      mem.mem_req = 1'b0;
      mem.mem_we  = 1'b0;
      ir_we       = 1'b0;
      pc_we       = 1'b0;
      pc_sel      = 2'd0;
      alu_op      = ALU_ADD;
      alu1_sel    = 1'b0;
      alu2_sel    = 1'b0;
      imm_type    = IMM_I;
      rd_sel      = 2'd0;
      reg_wr      = 1'b0;
      trap        = 1'b0;
    end

    instret_d = instret_q;
    if (pc_we && state_q != S_TRAP) instret_d = instret_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_FETCH;
      tmo_q     <= '0;
      cause_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      cause_q   <= cause_d;
      instret_q <= instret_d;
    end
  end

  assign trap_cause = cause_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios plus randomized
// instructions and memory wait states, checked against a per-instruction
// outcome model (latency, strobes, selects, traps, retirement).
module tb_multicycle_ctrl;
  localparam int unsigned T  = 4;
  localparam int unsigned CW = 8;

  localparam logic [4:0] LOAD = 5'b00000, OPIMM = 5'b00100, STORE = 5'b01000,
                         OP = 5'b01100, LUI = 5'b01101, BRANCH = 5'b11000,
                         JALR = 5'b11001, JAL = 5'b11011;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    opcode;
  logic [2:0]    func3;
  logic [6:0]    func7;
  logic          b;
  logic          ir_we, pc_we, alu1_sel, alu2_sel, reg_wr, trap;
  logic [1:0]    pc_sel, rd_sel, trap_cause;
  logic [3:0]    alu_op;
  logic [2:0]    imm_type;
  logic [CW-1:0] instret;

  multicycle_ctrl_if bus();

  multicycle_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .mem(bus.master),
    .opcode(opcode), .func3(func3), .func7(func7), .b(b),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .alu_op(alu_op),
    .alu1_sel(alu1_sel), .alu2_sel(alu2_sel), .imm_type(imm_type),
    .rd_sel(rd_sel), .reg_wr(reg_wr), .trap(trap), .trap_cause(trap_cause),
    .instret(instret)
  );

  always #5 clk = ~clk;

  int unsigned   n_checks = 0;
  int unsigned   n_fail   = 0;
  logic [CW-1:0] exp_instret = '0;
  logic [1:0]    exp_cause   = 2'd0;

  function automatic logic is_legal(input logic [4:0] op);
    return op inside {LOAD, OPIMM, STORE, OP, LUI, BRANCH, JALR, JAL};
  endfunction

  // Outcome of one instruction derived from the instruction-level rules.
  task automatic model_instr(
    input  logic [4:0] op, input logic [2:0] f3, input logic [6:0] f7,
    input  logic bv, input int unsigned df, input int unsigned dm,
    output int unsigned e_cyc, output int unsigned e_trap,
    output int unsigned e_reg, output int unsigned e_ir,
    output logic [1:0] e_psel, output logic [1:0] e_rsel,
    output logic e_retire, output logic [1:0] e_cause, output logic e_chk,
    output logic [3:0] e_aop, output logic e_a1, output logic e_a2,
    output logic [2:0] e_imm);
    int unsigned tbl [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    int unsigned fc;
    e_trap = 0; e_reg = 0; e_ir = 0; e_psel = 2'd0; e_rsel = 2'd0;
    e_retire = 1'b0; e_cause = 2'd0; e_chk = 1'b0;
    e_aop = 4'd0; e_a1 = 1'b0; e_a2 = 1'b1; e_imm = 3'd0;
    if (df >= T) begin
      e_cyc = T + 1; e_trap = 1; e_cause = 2'd2; e_psel = 2'd3;
      return;
    end
    fc = df + 1; e_ir = 1;
    if (!is_legal(op)) begin
      e_cyc = fc + 2; e_trap = 1; e_cause = 2'd1; e_psel = 2'd3;
      return;
    end
    e_chk = 1'b1;
    if (op == OP || op == OPIMM) begin
      e_aop = 4'(tbl[f3]);
      if (f3 == 3'd0 && op == OP && f7 == 7'h20) e_aop = 4'd1;
      if (f3 == 3'd5 && f7 == 7'h20) e_aop = 4'd7;
    end
    if (op == LUI) e_aop = 4'd10;
    e_a1 = (op == JAL || op == BRANCH);
    e_a2 = (op != OP);
    case (op)
      STORE:   e_imm = 3'd1;
      BRANCH:  e_imm = 3'd2;
      LUI:     e_imm = 3'd3;
      JAL:     e_imm = 3'd4;
      default: e_imm = 3'd0;
    endcase
    if (op == BRANCH) begin
      e_cyc = fc + 2; e_psel = {1'b0, bv}; e_retire = 1'b1;
    end else if (op == LOAD || op == STORE) begin
      if (dm >= T) begin
        e_cyc = fc + 2 + T + 1; e_trap = 1; e_cause = 2'd2; e_psel = 2'd3;
      end else if (op == STORE) begin
        e_cyc = fc + 2 + dm + 1; e_retire = 1'b1;
      end else begin
        e_cyc = fc + 2 + dm + 2; e_reg = 1; e_rsel = 2'd1; e_retire = 1'b1;
      end
    end else begin
      e_cyc = fc + 3; e_reg = 1; e_retire = 1'b1;
      if (op == JAL)  begin e_rsel = 2'd2; e_psel = 2'd1; end
      if (op == JALR) begin e_rsel = 2'd2; e_psel = 2'd2; end
    end
  endtask

  // Runs one instruction with df/dm wait cycles before ack in FETCH/MEM and
  // compares what was observed against the model. Call just after a negedge.
  task automatic run_instr(input string name, input logic [4:0] op,
                           input logic [2:0] f3, input logic [6:0] f7,
                           input logic bv, input int unsigned df,
                           input int unsigned dm);
    int unsigned e_cyc, e_trap, e_reg, e_ir;
    logic [1:0]  e_psel, e_rsel, e_cause;
    logic        e_retire, e_chk, e_a1, e_a2;
    logic [3:0]  e_aop;
    logic [2:0]  e_imm;
    int unsigned cyc = 0, reqcnt = 0, n_trap = 0, n_reg = 0, n_ir = 0, ir_cyc = 0;
    logic        done = 1'b0, x_seen = 1'b0;
    logic [1:0]  o_psel = 2'd0, o_rsel = 2'd0;
    logic [3:0]  x_aop = 4'd0;
    logic        x_a1 = 1'b0, x_a2 = 1'b0;
    logic [2:0]  x_imm = 3'd0;
    logic        exp_we;

    model_instr(op, f3, f7, bv, df, dm, e_cyc, e_trap, e_reg, e_ir, e_psel,
                e_rsel, e_retire, e_cause, e_chk, e_aop, e_a1, e_a2, e_imm);
    opcode = op; func3 = f3; func7 = f7; b = bv;

    while (!done && cyc < 64) begin
      cyc++;
      if (bus.mem_req) begin
        bus.mem_ack = (reqcnt == ((n_ir != 0) ? dm : df));
        reqcnt++;
      end else begin
        bus.mem_ack = 1'b0;
        reqcnt = 0;
      end
      #1;
      if (bus.mem_req) begin
        exp_we = (n_ir != 0) && (op == STORE);
        n_checks++;
        if (bus.mem_we !== exp_we) begin
          n_fail++;
          $display("FAIL %s mem_we cycle %0d: got %b want %b", name, cyc, bus.mem_we, exp_we);
        end
      end
      if (n_ir != 0 && cyc == ir_cyc + 2) begin
        x_seen = 1'b1; x_aop = alu_op; x_a1 = alu1_sel; x_a2 = alu2_sel; x_imm = imm_type;
      end
      if (ir_we === 1'b1) begin n_ir++; ir_cyc = cyc; end
      if (reg_wr === 1'b1) begin n_reg++; o_rsel = rd_sel; end
      if (trap === 1'b1) n_trap++;
      if (pc_we === 1'b1) begin done = 1'b1; o_psel = pc_sel; end
      @(negedge clk);
    end
    bus.mem_ack = 1'b0;

    if (e_retire) exp_instret = exp_instret + 1'b1;
    if (e_trap != 0) exp_cause = e_cause;

    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s completion: no pc_we within 64 cycles, want %0d cycles", name, e_cyc);
    end else if (cyc != e_cyc) begin
      n_fail++;
      $display("FAIL %s cycles: got %0d want %0d", name, cyc, e_cyc);
    end
    n_checks++;
    if (n_trap != e_trap) begin n_fail++; $display("FAIL %s trap pulses: got %0d want %0d", name, n_trap, e_trap); end
    n_checks++;
    if (n_reg != e_reg) begin n_fail++; $display("FAIL %s reg_wr cycles: got %0d want %0d", name, n_reg, e_reg); end
    n_checks++;
    if (n_ir != e_ir) begin n_fail++; $display("FAIL %s ir_we cycles: got %0d want %0d", name, n_ir, e_ir); end
    n_checks++;
    if (o_psel !== e_psel) begin n_fail++; $display("FAIL %s pc_sel: got %0d want %0d", name, o_psel, e_psel); end
    if (e_reg != 0) begin
      n_checks++;
      if (o_rsel !== e_rsel) begin n_fail++; $display("FAIL %s rd_sel: got %0d want %0d", name, o_rsel, e_rsel); end
    end
    if (e_chk) begin
      n_checks++;
      if (!x_seen || {x_aop, x_a1, x_a2, x_imm} !== {e_aop, e_a1, e_a2, e_imm}) begin
        n_fail++;
        $display("FAIL %s exec alu_op/alu1/alu2/imm: got %0d/%b/%b/%0d want %0d/%b/%b/%0d",
                 name, x_aop, x_a1, x_a2, x_imm, e_aop, e_a1, e_a2, e_imm);
      end
    end
    n_checks++;
    if (instret !== exp_instret) begin n_fail++; $display("FAIL %s instret: got %0d want %0d", name, instret, exp_instret); end
    n_checks++;
    if (trap_cause !== exp_cause) begin n_fail++; $display("FAIL %s trap_cause: got %0d want %0d", name, trap_cause, exp_cause); end
  endtask

  task automatic test_reset();
    rst = 1'b0; bus.mem_ack = 1'b1; opcode = OP; func3 = 3'd0; func7 = 7'd0; b = 1'b1;
    #12;
    n_checks++;
    if ({bus.mem_req, bus.mem_we, ir_we, pc_we, reg_wr, trap} !== 6'd0) begin
      n_fail++;
      $display("FAIL reset strobes: got %b want 000000",
               {bus.mem_req, bus.mem_we, ir_we, pc_we, reg_wr, trap});
    end
    n_checks++;
    if ({pc_sel, alu_op, alu1_sel, alu2_sel, imm_type, rd_sel} !== '0) begin
      n_fail++;
      $display("FAIL reset selects: got %h want 0", {pc_sel, alu_op, alu1_sel, alu2_sel, imm_type, rd_sel});
    end
    n_checks++;
    if (instret !== '0 || trap_cause !== 2'd0) begin
      n_fail++;
      $display("FAIL reset counters: instret %0d cause %0d want 0 0", instret, trap_cause);
    end
    bus.mem_ack = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL reset release fetch: mem_req %b mem_we %b want 1 0", bus.mem_req, bus.mem_we);
    end
    @(negedge clk);
  endtask

  task automatic test_alu_decode();
    run_instr("op_add",   OP,    3'b000, 7'b0000000, 1'b0, 0, 0);
    run_instr("op_sub",   OP,    3'b000, 7'b0100000, 1'b0, 0, 0);
    run_instr("opimm_00", OPIMM, 3'b000, 7'b0100000, 1'b0, 1, 0);
    run_instr("op_sra",   OP,    3'b101, 7'b0100000, 1'b0, 0, 0);
    run_instr("opimm_srl",OPIMM, 3'b101, 7'b0000000, 1'b0, 0, 0);
    run_instr("op_slt",   OP,    3'b010, 7'b0000000, 1'b0, 2, 0);
    run_instr("lui",      LUI,   3'b000, 7'b0000000, 1'b0, 0, 0);
    run_instr("jal",      JAL,   3'b000, 7'b0000000, 1'b0, 0, 0);
    run_instr("jalr",     JALR,  3'b000, 7'b0000000, 1'b0, 0, 0);
  endtask

  task automatic test_mem();
    run_instr("load_d3",  LOAD,  3'b010, 7'd0, 1'b0, 0, 3);
    run_instr("store",    STORE, 3'b010, 7'd0, 1'b0, 0, 0);
    run_instr("store_d2", STORE, 3'b010, 7'd0, 1'b0, 1, 2);
  endtask

  task automatic test_branch();
    run_instr("branch_t", BRANCH, 3'b000, 7'd0, 1'b1, 0, 0);
    run_instr("branch_n", BRANCH, 3'b001, 7'd0, 1'b0, 0, 0);
  endtask

  task automatic test_traps();
    run_instr("illegal",      5'b11111, 3'd0, 7'd0, 1'b0, 0, 0);
    run_instr("fetch_tmo",    OP,    3'd0, 7'd0, 1'b0, T, 0);
    run_instr("fetch_ack_lim",OP,    3'd0, 7'd0, 1'b0, T - 1, 0);
    run_instr("mem_tmo",      STORE, 3'd0, 7'd0, 1'b0, 0, T);
    run_instr("mem_ack_lim",  LOAD,  3'd0, 7'd0, 1'b0, 0, T - 1);
  endtask

  task automatic test_reset_mid_mem();
    opcode = LOAD; func3 = 3'd2; func7 = 7'd0; b = 1'b0;
    bus.mem_ack = 1'b1;                 // FETCH, immediate ack
    @(negedge clk); bus.mem_ack = 1'b0; // DECODE
    @(negedge clk);                     // EXEC
    @(negedge clk);                     // MEM, waiting
    #1;
    n_checks++;
    if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL midrst pre mem_req: got %b want 1", bus.mem_req); end
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.mem_req !== 1'b0 || reg_wr !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst drop: mem_req %b reg_wr %b want 0 0", bus.mem_req, reg_wr);
    end
    n_checks++;
    if (instret !== '0 || trap_cause !== 2'd0) begin
      n_fail++;
      $display("FAIL midrst clear: instret %0d cause %0d want 0 0", instret, trap_cause);
    end
    exp_instret = '0; exp_cause = 2'd0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst fetch after release: mem_req %b mem_we %b want 1 0", bus.mem_req, bus.mem_we);
    end
    run_instr("after_rst", OP, 3'b110, 7'd0, 1'b0, 0, 0);
  endtask

  task automatic test_random(input int unsigned n);
    logic [4:0] legal_ops [8] = '{LOAD, OPIMM, STORE, OP, LUI, BRANCH, JALR, JAL};
    logic [4:0] op;
    logic [6:0] f7;
    for (int i = 0; i < int'(n); i++) begin
      if ($urandom_range(0, 3) == 0) op = 5'($urandom_range(0, 31));
      else op = legal_ops[$urandom_range(0, 7)];
      f7 = ($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'($urandom_range(0, 127));
      run_instr("random", op, 3'($urandom_range(0, 7)), f7, 1'($urandom_range(0, 1)),
                $urandom_range(0, 5), $urandom_range(0, 5));
    end
  endtask

  initial begin
    bus.mem_ack = 1'b0;
    test_reset();
    test_alu_decode();
    test_mem();
    test_branch();
    test_traps();
    test_reset_mid_mem();
    test_random(400);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
